axi_rr_read_arbiter: RTL

AXI_RR_READ_ARBITER -- requirements
Module: axi_rr_read_arbiter

---
 rtl/axi_rr_read_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axi_rr_read_arbiter.sv
// Round-robin arbiter sharing one downstream AXI read port among NM upstream masters.
// Exactly one read transaction is in flight at a time: address, then its data burst.
module axi_rr_read_arbiter #(
  parameter int NM  = 3,
  parameter int AW  = 64,
  parameter int DW  = 32,
  parameter int IDW = 4,
  localparam int ARP = IDW + 2 + 8 + 3 + AW,
  localparam int RP  = IDW + 2 + 1 + DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     s_ar_valid,
  output logic [NM-1:0]     s_ar_ready,
  input  logic [NM*ARP-1:0] s_ar_pld,
  output logic [NM-1:0]     s_r_valid,
  input  logic [NM-1:0]     s_r_ready,
  output logic [NM*RP-1:0]  s_r_pld,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ARP-1:0]    m_ar_pld,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [RP-1:0]     m_r_pld,
  output logic [NM-1:0]     grant,
  output logic              err_len
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e         st_q, st_d;
  logic [NM-1:0]  grant_q, grant_d;
  logic [IW-1:0]  last_q, last_d;
  logic [ARP-1:0] pld_q, pld_d;
  logic [8:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           hi_found, lo_found, win_found;
  logic [IW-1:0]  hi_idx, lo_idx, win_idx;
  logic [NM-1:0]  win_oh;
  logic [8:0]     cnt_inc, beats_exp;
  logic           beat_last, r_hs;

  // Requesters above last_q outrank those at or below it; lowest index wins within each group.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NM - 1; j >= 0; j--) begin
      if (s_ar_valid[j]) begin
        if (j > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IW'(j);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    win_oh    = win_found ? (NM'(1) << win_idx) : '0;
  end

  assign beats_exp = {1'b0, pld_q[AW+3 +: 8]} + 9'd1;
  assign cnt_inc   = cnt_q + 9'd1;
  assign beat_last = m_r_pld[DW];

  always_comb begin
    st_d       = st_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pld_d      = pld_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    s_ar_ready = '0;
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b0;
    s_r_valid  = '0;
    s_r_pld    = '0;
    r_hs       = 1'b0;
    unique case (st_q)
      StIdle: begin
        // Gating with rst keeps ready low while reset is held.
        if (win_found && !rst) begin
          s_ar_ready = win_oh;
          for (int k = 0; k < NM; k++) begin
            if (win_oh[k]) pld_d = s_ar_pld[k*ARP +: ARP];
          end
          grant_d = win_oh;
          last_d  = win_idx;
          cnt_d   = '0;
          st_d    = StAddr;
        end
      end
      StAddr: begin
        m_ar_valid = 1'b1;
        if (m_ar_ready) st_d = StData;
      end
      StData: begin
        m_r_ready = |(s_r_ready & grant_q);
        s_r_valid = grant_q & {NM{m_r_valid}};
        for (int k = 0; k < NM; k++) begin
          if (grant_q[k]) s_r_pld[k*RP +: RP] = m_r_pld;
        end
        r_hs = m_r_valid & m_r_ready;
        if (r_hs) begin
          if (beat_last) begin
            if (cnt_inc != beats_exp) err_d = 1'b1;
            cnt_d   = '0;
            grant_d = '0;
            st_d    = StIdle;
          end else begin
            if (cnt_inc == beats_exp) err_d = 1'b1;
            cnt_d = cnt_inc;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
      pld_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pld_q   <= pld_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m_ar_pld = pld_q;
  assign grant    = grant_q;
  assign err_len  = err_q;

endmodule
